// File: rtl/burst_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_link_pkg
// Description : Shared widths, state and opcode types for the burst link
//               requester/responder pair.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package burst_link_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    RQ_IDLE = 2'd0,
    RQ_REQ  = 2'd1,
    RQ_DATA = 2'd2,
    RQ_DONE = 2'd3
  } req_state_t;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_WRITE = 2'd1,
    RS_READ  = 2'd2,
    RS_RESP  = 2'd3
  } rsp_state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/burst_link_if.sv
`default_nettype none
// ============================================================================
// Module      : burst_link_if
// Description : Command/data bus of the burst link.
// Ports       : master - drives command, write data and ready; receives rdata
//               slave  - receives command, write data and ready; drives rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface burst_link_if;
  import burst_link_pkg::*;

  logic              io_start;
  logic              io_top_wr;
  logic              io_top_rd;
  logic [ADDR_W-1:0] io_top_address;
  logic [LEN_W-1:0]  io_top_length;
  logic [DATA_W-1:0] io_top_wdata;
  logic              io_top_ready;
  logic [DATA_W-1:0] io_top_rdata;

  modport master (
    output io_start, io_top_wr, io_top_rd, io_top_address, io_top_length,
           io_top_wdata, io_top_ready,
    input  io_top_rdata
  );

  modport slave (
    input  io_start, io_top_wr, io_top_rd, io_top_address, io_top_length,
           io_top_wdata, io_top_ready,
    output io_top_rdata
  );

endinterface
`default_nettype wire

// File: rtl/burst_link_requester.sv
`default_nettype none
// ============================================================================
// Module      : burst_requester
// Description : Accepts a burst command in IDLE, presents it for one cycle,
//               then counts beats and steps the address on each ready cycle.
// Ports       : clock, reset (async, active-low)
//               start_i/wr_i/rd_i/addr_i/len_i - command inputs
//               ready_i     - beat qualifier
//               cmd_valid_o - command presented (REQ cycle)
//               op_o        - latched operation
//               beat_o      - a beat completes this cycle
//               last_o      - the completing beat is the final one
//               addr_o      - address of the current beat
// Revision    : 1.0 - initial release
// ============================================================================
module burst_requester
  import burst_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              ready_i,
  output logic              cmd_valid_o,
  output op_t               op_o,
  output logic              beat_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  req_state_t        state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              w_cmd_ok;
  logic              w_beat;
  logic              w_last;

  // Exactly one of wr/rd and a non-zero length make a legal command.
  assign w_cmd_ok = start_i && (wr_i ^ rd_i) && (len_i != '0);
  assign w_beat   = (state_q == RQ_DATA) && ready_i;
  assign w_last   = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      RQ_IDLE: begin
        if (w_cmd_ok) begin
          op_d    = wr_i ? OP_WR : OP_RD;
          addr_d  = addr_i;
          len_d   = len_i;
          cnt_d   = '0;
          state_d = RQ_REQ;
        end
      end
      RQ_REQ:  state_d = RQ_DATA;
      RQ_DATA: begin
        if (ready_i) begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;   // natural wrap at the top of the file
          if (w_last) state_d = RQ_DONE;
        end
      end
      RQ_DONE: state_d = RQ_IDLE;
      default: state_d = RQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RQ_IDLE;
      op_q    <= OP_WR;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_valid_o = (state_q == RQ_REQ);
  assign op_o        = op_q;
  assign beat_o      = w_beat;
  assign last_o      = w_beat && w_last;
  assign addr_o      = addr_q;

endmodule
`default_nettype wire

// File: rtl/burst_link_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_responder
// Description : Owns the register file; follows the requester through a
//               write or read burst and holds the last read beat in rdata.
// Ports       : clock, reset (async, active-low)
//               cmd_valid_i/op_i - command from requester
//               beat_i/last_i    - beat qualifiers from requester
//               addr_i           - current beat address
//               wdata_i          - write data of the current beat
//               rdata_o          - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module burst_responder
  import burst_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid_i,
  input  op_t               op_i,
  input  logic              beat_i,
  input  logic              last_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  rsp_state_t        state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_IDLE:  if (cmd_valid_i) state_d = (op_i == OP_WR) ? RS_WRITE : RS_READ;
      RS_WRITE: if (last_i) state_d = RS_RESP;
      RS_READ:  if (last_i) state_d = RS_RESP;
      RS_RESP:  state_d = RS_IDLE;   // lines up with the requester DONE cycle
      default:  state_d = RS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RS_IDLE;
    else        state_q <= state_d;
  end

  // Reset clears the whole file, so an aborted burst leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if ((state_q == RS_WRITE) && beat_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              rdata_q <= '0;
    else if ((state_q == RS_READ) && beat_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/burst_link_top.sv
`default_nettype none
// ============================================================================
// Module      : burst_link_top
// Description : Pairs the burst requester with the register-file responder.
// Ports       : clock - single rising-edge clock
//               reset - asynchronous, active-low
//               bus   - burst_link_if slave (command, wdata, ready, rdata)
// Revision    : 1.0 - initial release
// ============================================================================
module burst_link_top
  import burst_link_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  burst_link_if.slave bus
);

  logic              w_cmd_valid;
  op_t               w_op;
  logic              w_beat;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  burst_requester u_req (
    .clock       (clock),
    .reset       (reset),
    .start_i     (bus.io_start),
    .wr_i        (bus.io_top_wr),
    .rd_i        (bus.io_top_rd),
    .addr_i      (bus.io_top_address),
    .len_i       (bus.io_top_length),
    .ready_i     (bus.io_top_ready),
    .cmd_valid_o (w_cmd_valid),
    .op_o        (w_op),
    .beat_o      (w_beat),
    .last_o      (w_last),
    .addr_o      (w_addr)
  );

  burst_responder u_rsp (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid_i (w_cmd_valid),
    .op_i        (w_op),
    .beat_i      (w_beat),
    .last_i      (w_last),
    .addr_i      (w_addr),
    .wdata_i     (bus.io_top_wdata),
    .rdata_o     (bus.io_top_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_burst_link_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_link_top
// Description : Self-checking bench for burst_link_top with a memory-array
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_link_top;
  import burst_link_pkg::*;

  typedef logic [31:0] wq_t[$];

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  burst_link_if bus();

  burst_link_top dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain array of the register file plus last read value.
  logic [31:0] mem_m [16];
  logic [31:0] rd_m;

  // Per data-phase cycle: ready driven, rdata seen after that edge.
  logic [31:0] obs_q[$];
  bit          rdy_q[$];

  task automatic idle_inputs();
    bus.io_start       = 1'b0;
    bus.io_top_wr      = 1'b0;
    bus.io_top_rd      = 1'b0;
    bus.io_top_address = '0;
    bus.io_top_length  = '0;
    bus.io_top_wdata   = '0;
    bus.io_top_ready   = 1'b0;
  endtask

  task automatic rand_words(output wq_t q);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back($urandom() | 32'h1);
  endtask

  // Called at a negedge while the link is idle; leaves us at the negedge
  // that starts the REQ cycle.
  task automatic issue(input bit wr, input bit rd, input logic [3:0] a,
                       input logic [3:0] l, input logic [31:0] wd0);
    bus.io_start       = 1'b1;
    bus.io_top_wr      = wr;
    bus.io_top_rd      = rd;
    bus.io_top_address = a;
    bus.io_top_length  = l;
    bus.io_top_wdata   = wd0;
    bus.io_top_ready   = 1'($urandom_range(0, 1));
    @(negedge clock);
    bus.io_start       = 1'b0;
    bus.io_top_wr      = 1'b0;
    bus.io_top_rd      = 1'b0;
    bus.io_top_address = 4'($urandom());
    bus.io_top_length  = 4'($urandom());
    bus.io_top_ready   = 1'($urandom_range(0, 1));
  endtask

  // Drives the data phase (mode 0: ready high, 1: 1,0,1,0.., 2: random,
  // 3: low three cycles then high), then the DONE cycle; ends at an idle negedge.
  task automatic run_data(input int len, input wq_t wd, input int mode);
    int beats = 0;
    int cyc   = 0;
    bit r;
    obs_q.delete();
    rdy_q.delete();
    @(negedge clock);
    while (beats < len) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        3:       r = (cyc >= 3);
        default: r = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      bus.io_top_ready = r;
      bus.io_top_wdata = r ? wd[beats] : $urandom();
      @(negedge clock);
      rdy_q.push_back(r);
      obs_q.push_back(bus.io_top_rdata);
      if (r) beats++;
      cyc++;
    end
    bus.io_top_ready = 1'($urandom_range(0, 1));
    bus.io_top_wdata = $urandom();
    @(negedge clock);
    bus.io_top_ready = 1'b0;
  endtask

  // Expected rdata after each recorded data cycle.
  function automatic wq_t expect_obs(input bit wr, input logic [3:0] a);
    wq_t e = {};
    logic [31:0] cur = rd_m;
    int k = 0;
    for (int i = 0; i < rdy_q.size(); i++) begin
      if (rdy_q[i] && !wr) cur = mem_m[(int'(a) + k) % 16];
      if (rdy_q[i]) k++;
      e.push_back(cur);
    end
    return e;
  endfunction

  task automatic model_burst(input bit wr, input logic [3:0] a,
                             input int l, input wq_t wd);
    for (int i = 0; i < l; i++) begin
      if (wr) mem_m[(int'(a) + i) % 16] = wd[i];
      else    rd_m = mem_m[(int'(a) + i) % 16];
    end
  endtask

  task automatic test_reset();
    wq_t wd, ex;
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.io_top_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", bus.io_top_rdata);
    end
    checks++;
    if (dut.u_req.state_q !== RQ_IDLE || dut.u_rsp.state_q !== RS_IDLE) begin
      errors++; $display("FAIL reset_state: got req=%0d rsp=%0d expected 0/0",
                         dut.u_req.state_q, dut.u_rsp.state_q);
    end
    reset = 1'b1;
    @(negedge clock);
    // Fill four entries, then abort a read burst part way through.
    rand_words(wd);
    issue(1, 0, 4'd0, 4'd4, wd[0]);
    run_data(4, wd, 0);
    model_burst(1, 4'd0, 4, wd);
    issue(0, 1, 4'd0, 4'd4, 32'h0);
    @(negedge clock);
    bus.io_top_ready = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.io_top_rdata !== mem_m[1]) begin
      errors++; $display("FAIL mid_read: got %h expected %h", bus.io_top_rdata, mem_m[1]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.io_top_rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset_rdata: got %h expected 0", bus.io_top_rdata);
    end
    checks++;
    if (dut.u_req.state_q !== RQ_IDLE || dut.u_rsp.state_q !== RS_IDLE) begin
      errors++; $display("FAIL async_reset_state: got req=%0d rsp=%0d expected 0/0",
                         dut.u_req.state_q, dut.u_rsp.state_q);
    end
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0;
    @(negedge clock);
    reset = 1'b1;
    bus.io_top_ready = 1'b0;
    @(negedge clock);
    issue(0, 1, 4'd0, 4'd4, 32'h0);
    run_data(4, wd, 0);
    ex = expect_obs(0, 4'd0);
    model_burst(0, 4'd0, 4, wd);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ex[i]) begin
        errors++; $display("FAIL reset_cleared[%0d]: got %h expected %h", i, obs_q[i], ex[i]);
      end
    end
  endtask

  task automatic test_single_write_read();
    wq_t wd;
    logic [31:0] old6 = mem_m[6];
    issue(1, 0, 4'd6, 4'd1, 32'hA);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus.io_top_ready = 1'b0;
      bus.io_top_wdata = 32'hA;
      @(negedge clock);
      checks++;
      if (dut.u_rsp.mem_q[6] !== old6) begin
        errors++; $display("FAIL stall_no_write[%0d]: got %h expected %h", i, dut.u_rsp.mem_q[6], old6);
      end
    end
    bus.io_top_ready = 1'b1;
    bus.io_top_wdata = 32'hA;
    @(negedge clock);
    bus.io_top_ready = 1'b0;
    bus.io_top_wdata = 32'h0;
    checks++;
    if (dut.u_rsp.mem_q[6] !== 32'hA) begin
      errors++; $display("FAIL single_write: got %h expected %h", dut.u_rsp.mem_q[6], 32'hA);
    end
    checks++;
    if (bus.io_top_rdata !== rd_m) begin
      errors++; $display("FAIL write_keeps_rdata: got %h expected %h", bus.io_top_rdata, rd_m);
    end
    mem_m[6] = 32'hA;
    @(negedge clock);
    wd = {32'h0};
    issue(0, 1, 4'd6, 4'd1, 32'h0);
    run_data(1, wd, 0);
    checks++;
    if (obs_q[0] !== 32'hA) begin
      errors++; $display("FAIL single_read_latency: got %h expected %h", obs_q[0], 32'hA);
    end
    rd_m = 32'hA;
  endtask

  task automatic test_wrap();
    wq_t wd, rq, ex;
    wd = {32'hB, 32'hC, 32'hD};
    issue(1, 0, 4'd14, 4'd3, wd[0]);
    run_data(3, wd, 2);
    ex = expect_obs(1, 4'd14);
    model_burst(1, 4'd14, 3, wd);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ex[i]) begin
        errors++; $display("FAIL wrap_write_rdata[%0d]: got %h expected %h", i, obs_q[i], ex[i]);
      end
    end
    rand_words(rq);
    issue(0, 1, 4'd14, 4'd3, 32'h0);
    run_data(3, rq, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q[i] !== wd[i]) begin
        errors++; $display("FAIL wrap_read[%0d]: got %h expected %h", i, obs_q[i], wd[i]);
      end
    end
    rd_m = 32'hD;
  endtask

  task automatic test_stall();
    wq_t rq, ex;
    int changes = 0;
    logic [31:0] prev = rd_m;
    rand_words(rq);
    issue(0, 1, 4'd14, 4'd3, 32'h0);
    run_data(3, rq, 1);
    ex = expect_obs(0, 4'd14);
    model_burst(0, 4'd14, 3, rq);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ex[i]) begin
        errors++; $display("FAIL stall_read[%0d]: got %h expected %h ready=%0d", i, obs_q[i], ex[i], rdy_q[i]);
      end
      if (obs_q[i] !== prev) changes++;
      prev = obs_q[i];
    end
    checks++;
    if (changes != 3) begin
      errors++; $display("FAIL stall_updates: got %0d expected 3", changes);
    end
  endtask

  task automatic test_illegal();
    wq_t rq, ex;
    bit wr_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit rd_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] ln_v [4] = '{4'd5, 4'd5, 4'd0, 4'd0};
    for (int k = 0; k < 4; k++) begin
      issue(wr_v[k], rd_v[k], 4'($urandom()), ln_v[k], $urandom());
      for (int c = 0; c < 5; c++) begin
        bus.io_top_ready = 1'b1;
        bus.io_top_wdata = $urandom();
        @(negedge clock);
      end
      bus.io_top_ready = 1'b0;
      checks++;
      if (bus.io_top_rdata !== rd_m) begin
        errors++; $display("FAIL illegal_rdata[%0d]: got %h expected %h", k, bus.io_top_rdata, rd_m);
      end
      checks++;
      if (dut.u_req.state_q !== RQ_IDLE) begin
        errors++; $display("FAIL illegal_state[%0d]: got %0d expected 0", k, dut.u_req.state_q);
      end
    end
    rand_words(rq);
    issue(0, 1, 4'd0, 4'd15, 32'h0);
    run_data(15, rq, 0);
    ex = expect_obs(0, 4'd0);
    model_burst(0, 4'd0, 15, rq);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ex[i]) begin
        errors++; $display("FAIL illegal_mem[%0d]: got %h expected %h", i, obs_q[i], ex[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    wq_t wd, rq, ex;
    logic [31:0] bad;
    rand_words(wd);
    bad = ~mem_m[9];
    issue(1, 0, 4'd3, 4'd2, wd[0]);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      bus.io_start       = 1'b1;
      bus.io_top_wr      = 1'b1;
      bus.io_top_rd      = 1'b0;
      bus.io_top_address = 4'd9;
      bus.io_top_length  = 4'd1;
      bus.io_top_ready   = 1'b1;
      bus.io_top_wdata   = (i < 2) ? wd[i] : bad;
      @(negedge clock);
    end
    idle_inputs();
    model_burst(1, 4'd3, 2, wd);
    for (int c = 0; c < 4; c++) begin
      bus.io_top_ready = 1'b1;
      bus.io_top_wdata = bad;
      @(negedge clock);
    end
    bus.io_top_ready = 1'b0;
    checks++;
    if (dut.u_req.state_q !== RQ_IDLE) begin
      errors++; $display("FAIL busy_state: got %0d expected 0", dut.u_req.state_q);
    end
    rand_words(rq);
    issue(0, 1, 4'd3, 4'd7, 32'h0);
    run_data(7, rq, 2);
    ex = expect_obs(0, 4'd3);
    model_burst(0, 4'd3, 7, rq);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ex[i]) begin
        errors++; $display("FAIL busy_mem[%0d]: got %h expected %h", i, obs_q[i], ex[i]);
      end
    end
  endtask

  // Commands issued in the first idle cycle after each DONE.
  task automatic test_back_to_back();
    wq_t wd, ex;
    for (int n = 0; n < 30; n++) begin
      bit wr = 1'($urandom_range(0, 1));
      logic [3:0] a = 4'($urandom());
      int l = $urandom_range(1, 15);
      rand_words(wd);
      issue(wr, !wr, a, 4'(l), wd[0]);
      run_data(l, wd, 2);
      ex = expect_obs(wr, a);
      model_burst(wr, a, l, wd);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== ex[i]) begin
          errors++; $display("FAIL b2b[%0d][%0d]: got %h expected %h", n, i, obs_q[i], ex[i]);
        end
      end
    end
    rand_words(wd);
    issue(0, 1, 4'd0, 4'd15, 32'h0);
    run_data(15, wd, 0);
    ex = expect_obs(0, 4'd0);
    model_burst(0, 4'd0, 15, wd);
    issue(0, 1, 4'd15, 4'd1, 32'h0);
    run_data(1, wd, 0);
    ex.push_back(mem_m[15]);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (ex[i] !== mem_m[i]) begin
        errors++; $display("FAIL b2b_dump_model[%0d]: got %h expected %h", i, ex[i], mem_m[i]);
      end
    end
    checks++;
    if (obs_q[0] !== mem_m[15]) begin
      errors++; $display("FAIL b2b_dump15: got %h expected %h", obs_q[0], mem_m[15]);
    end
    rd_m = mem_m[15];
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_wrap();
    test_stall();
    test_illegal();
    test_busy_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
